vram_arbiter: RTL and testbench

- Shares the single external async SRAM (19-bit address, 8-bit bidirectional data, active-low WE/OE) between two requesters.
- Requester one is the video scan-out read port, which has a hard deadline and absolute priority.
- Requester two is the SPI pixel-write port, which is buffered in a small write FIFO and drained in free bus slots.
- Sits between the SPI byte assembler / scan-out counter and the top-level SRAM pins. It owns all SRAM timing (setup, WE pulse, hold, bus turnaround).

---
 rtl/vram_pkg.sv | 21 ++
 rtl/vram_wr_fifo.sv | 51 +++++
 rtl/vram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared widths, FSM state encoding and write-entry layout for the VRAM arbiter.
package vram_pkg;

   localparam int unsigned DEF_ADDR_W = 19;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StTurn,
      StWrSetup,
      StWrPulse,
      StWrHold
   } state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO of packed {addr, data} write entries.
// A push while full is dropped even if a pop happens in the same cycle.
module vram_wr_fifo
   import vram_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = $bits(wr_entry_t)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Depth is a power of two, so the pointers wrap by plain overflow.
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
         else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/vram_arbiter.sv
// SRAM arbiter: scan-out reads have absolute priority, SPI writes drain from a FIFO in free slots.
// Define VRAM_STATS_EN to build the completed-write and read-stall statistics counters.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned RD_CYCLES   = 2,
   parameter int unsigned WR_CYCLES   = 2,
   parameter int unsigned WFIFO_DEPTH = 4
) (
   input  logic              MainClkSrc,
   input  logic              ResetN,
   input  logic              RdReq,
   input  logic [ADDR_W-1:0] RdAddr,
   output logic [DATA_W-1:0] RdData,
   output logic              RdValid,
   output logic              RdOverrun,
   input  logic              WrReq,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [DATA_W-1:0] WrData,
   output logic              WrReady,
   output logic [ADDR_W-1:0] MemAddr,
   inout  wire  [DATA_W-1:0] MemData,
   output logic              MemWE,
   output logic              MemOE,
   output logic [15:0]       StatWrCount,
   output logic [15:0]       StatRdStall
);

   localparam int unsigned EntryW = ADDR_W + DATA_W;
   localparam int unsigned MaxCyc = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   state_t            state_q;
   logic [CntW-1:0]   cyc_q;
   logic              rd_pend_q, overrun_q;
   logic [ADDR_W-1:0] rd_addr_q, mem_addr_q;
   logic [DATA_W-1:0] wdata_q, rd_data_q;
   logic              drive_q, we_n_q, oe_n_q, rd_valid_q;
   logic [EntryW-1:0] head;
   logic              fifo_full, fifo_empty, rd_take, fifo_pop;

   assign rd_take  = (state_q == StIdle) && rd_pend_q;
   assign fifo_pop = (state_q == StWrHold);

   vram_wr_fifo #(
      .DEPTH (WFIFO_DEPTH),
      .WIDTH (EntryW)
   ) u_wr_fifo (
      .clk   (MainClkSrc),
      .rst_n (ResetN),
      .push  (WrReq),
      .wdata ({WrAddr, WrData}),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // One-entry read latch; a request landing on the consume edge refills it.
   always_ff @(posedge MainClkSrc or negedge ResetN) begin
      if (!ResetN) begin
         rd_pend_q <= 1'b0;
         rd_addr_q <= '0;
         overrun_q <= 1'b0;
      end else if (RdReq) begin
         if (rd_pend_q && !rd_take) begin
            overrun_q <= 1'b1;
         end else begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= RdAddr;
         end
      end else if (rd_take) begin
         rd_pend_q <= 1'b0;
      end
   end

   always_ff @(posedge MainClkSrc or negedge ResetN) begin
      if (!ResetN) begin
         state_q    <= StIdle;
         cyc_q      <= '0;
         mem_addr_q <= '0;
         wdata_q    <= '0;
         drive_q    <= 1'b0;
         we_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rd_pend_q) begin
                  state_q    <= StRd;
                  mem_addr_q <= rd_addr_q;
                  oe_n_q     <= 1'b0;
                  cyc_q      <= '0;
               end else if (!fifo_empty) begin
                  state_q    <= StWrSetup;
                  mem_addr_q <= head[EntryW-1 -: ADDR_W];
                  wdata_q    <= head[DATA_W-1:0];
                  drive_q    <= 1'b1;
               end
            end
            StRd: begin
               if (cyc_q == CntW'(RD_CYCLES - 1)) begin
                  rd_data_q  <= MemData;
                  rd_valid_q <= 1'b1;
                  oe_n_q     <= 1'b1;
                  state_q    <= StTurn;
               end else begin
                  cyc_q <= cyc_q + 1'b1;
               end
            end
            StTurn: state_q <= StIdle;
            StWrSetup: begin
               we_n_q  <= 1'b0;
               cyc_q   <= '0;
               state_q <= StWrPulse;
            end
            StWrPulse: begin
               if (cyc_q == CntW'(WR_CYCLES - 1)) begin
                  we_n_q  <= 1'b1;
                  state_q <= StWrHold;
               end else begin
                  cyc_q <= cyc_q + 1'b1;
               end
            end
            StWrHold: begin
               // Bus released on entry to IDLE, so a following read needs no TURN.
               drive_q <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign MemAddr   = mem_addr_q;
   assign MemData   = drive_q ? wdata_q : {DATA_W{1'bz}};
   assign MemWE     = we_n_q;
   assign MemOE     = oe_n_q;
   assign RdData    = rd_data_q;
   assign RdValid   = rd_valid_q;
   assign RdOverrun = overrun_q;
   assign WrReady   = !fifo_full;

`ifdef VRAM_STATS_EN
   logic [15:0] wr_cnt_q, stall_q;
   logic        in_wr;

   assign in_wr = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);

   always_ff @(posedge MainClkSrc or negedge ResetN) begin
      if (!ResetN) begin
         wr_cnt_q <= '0;
         stall_q  <= '0;
      end else begin
         if (state_q == StWrHold) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (rd_pend_q && in_wr && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      end
   end

   assign StatWrCount = wr_cnt_q;
   assign StatRdStall = stall_q;
`else
   assign StatWrCount = '0;
   assign StatRdStall = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural SRAM, read/write scoreboards fed by directed scenarios.
module tb_vram_arbiter;

   localparam int unsigned AW = 19;
   localparam int unsigned DW = 8;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          rd_req  = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          wr_req  = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, rd_overrun, wr_ready, mem_we, mem_oe;
   logic [AW-1:0] mem_addr;
   wire  [DW-1:0] mem_data;
   logic [15:0]   stat_wr, stat_stall;

   vram_arbiter dut (
      .MainClkSrc  (clk),
      .ResetN      (rst_n),
      .RdReq       (rd_req),
      .RdAddr      (rd_addr),
      .RdData      (rd_data),
      .RdValid     (rd_valid),
      .RdOverrun   (rd_overrun),
      .WrReq       (wr_req),
      .WrAddr      (wr_addr),
      .WrData      (wr_data),
      .WrReady     (wr_ready),
      .MemAddr     (mem_addr),
      .MemData     (mem_data),
      .MemWE       (mem_we),
      .MemOE       (mem_oe),
      .StatWrCount (stat_wr),
      .StatRdStall (stat_stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      int unsigned   due;
   } rd_exp_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_exp_t;

   rd_exp_t     rd_q[$];
   wr_exp_t     wr_q[$];
   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned oe_low = 0, we_low = 0, c0_cnt = 0, contention = 0;
   int unsigned last_oe_cyc = 0, last_we_cyc = 0;
   logic [7:0]  sram [1024];

   // SRAM drives the bus whenever OE is low.
   assign mem_data = (mem_oe == 1'b0) ? sram[mem_addr[9:0]] : 8'bz;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Read monitor plus bus activity counters.
   always @(negedge clk) begin
      rd_exp_t e;
      if (rd_valid === 1'b1) begin
         if (rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got data %0h with no read outstanding", rd_data);
         end else begin
            e = rd_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(e.data));
            check("rd_latency", cyc, e.due);
         end
      end
      if (mem_oe === 1'b0) begin
         oe_low++;
         last_oe_cyc = cyc;
      end
      if (mem_we === 1'b0) begin
         we_low++;
         last_we_cyc = cyc;
      end
      if (mem_data === 8'hC0) c0_cnt++;
      if (mem_oe === 1'b0 && (mem_we === 1'b0 || mem_data !== sram[mem_addr[9:0]])) contention++;
   end

   // Write monitor: the SRAM latches on the rising WE edge.
   always @(posedge mem_we) begin
      wr_exp_t w;
      if (rst_n === 1'b1) begin
         sram[mem_addr[9:0]] = mem_data;
         if (wr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wr_unexpected: got addr %0h data %0h with no write outstanding",
                     mem_addr, mem_data);
         end else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(w.addr));
            check("wr_data", 32'(mem_data), 32'(w.data));
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int unsigned lat);
      rd_req  = 1'b1;
      rd_addr = a;
      rd_q.push_back('{data: d, due: cyc + 1 + lat});
      tick();
      rd_req = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int held);
      held    = 0;
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      while (wr_ready !== 1'b1 && held < 20) begin
         tick();
         held++;
      end
      if (wr_ready === 1'b1) wr_q.push_back('{addr: a, data: d});
      tick();
      wr_req = 1'b0;
   endtask

   initial begin
      int          held;
      int unsigned b_oe, b_we, b_c0, b_ct, s;

      for (int i = 0; i < 1024; i++) sram[i] = 8'h00;
      sram[10'h123] = 8'hA5;

      do_reset();
      check("rst_we", 32'(mem_we), 1);
      check("rst_oe", 32'(mem_oe), 1);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_overrun", 32'(rd_overrun), 0);
      check("rst_wr_ready", 32'(wr_ready), 1);
      check("rst_stat_wr", 32'(stat_wr), 0);
      check("rst_stat_stall", 32'(stat_stall), 0);

      // Idle read
      b_oe = oe_low;
      do_read(19'h00123, 8'hA5, 3);
      tick(8);
      check("t1_oe_low_cycles", oe_low - b_oe, 2);
      check("t1_rd_outstanding", rd_q.size(), 0);

      // Single write
      do_reset();
      b_we = we_low;
      b_c0 = c0_cnt;
      do_write(19'h00010, 8'hC0, held);
      tick(10);
      check("t2_data_cycles", c0_cnt - b_c0, 4);
      check("t2_we_low_cycles", we_low - b_we, 2);
      check("t2_sram", 32'(sram[10'h010]), 32'h0C0);
`ifdef VRAM_STATS_EN
      check("t2_stat_wr", 32'(stat_wr), 1);
`else
      check("t2_stat_wr", 32'(stat_wr), 0);
`endif

      // Five back-to-back pushes; the fifth waits for the first pop
      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_write(19'h00020 + AW'(i), 8'(8'h11 * (i + 1)), held);
         check("t3_held_cycles", held, (i == 4) ? 2 : 0);
      end
      tick(30);
      check("t3_wr_outstanding", wr_q.size(), 0);
      check("t3_sram_last", 32'(sram[10'h024]), 32'h55);
`ifdef VRAM_STATS_EN
      check("t3_stat_wr", 32'(stat_wr), 5);
`endif

      // Read arriving one cycle into a write waits for it
      do_reset();
      b_ct = contention;
      do_write(19'h00030, 8'h77, held);
      tick();
      do_read(19'h00123, 8'hA5, 6);
      tick(12);
      check("t4_rd_outstanding", rd_q.size(), 0);
      check("t4_contention", contention - b_ct, 0);
      check("t4_sram", 32'(sram[10'h030]), 32'h77);
`ifdef VRAM_STATS_EN
      check("t4_stat_stall", 32'(stat_stall), 3);
`else
      check("t4_stat_stall", 32'(stat_stall), 0);
`endif

      // Read and write requested together: read, TURN, then write
      do_reset();
      b_ct = contention;
      b_oe = oe_low;
      b_we = we_low;
      s = cyc;
      wr_req  = 1'b1;
      wr_addr = 19'h00050;
      wr_data = 8'h3C;
      wr_q.push_back('{addr: 19'h00050, data: 8'h3C});
      rd_req  = 1'b1;
      rd_addr = 19'h00123;
      rd_q.push_back('{data: 8'hA5, due: s + 4});
      tick();
      wr_req = 1'b0;
      rd_req = 1'b0;
      tick(14);
      check("t5_last_oe_cycle", last_oe_cyc, s + 3);
      check("t5_last_we_cycle", last_we_cyc, s + 8);
      check("t5_oe_low_cycles", oe_low - b_oe, 2);
      check("t5_we_low_cycles", we_low - b_we, 2);
      check("t5_contention", contention - b_ct, 0);
      check("t5_sram", 32'(sram[10'h050]), 32'h3C);

      // Two reads one cycle apart during a write
      do_reset();
      do_write(19'h00060, 8'hE1, held);
      tick();
      do_read(19'h00123, 8'hA5, 6);
      rd_req  = 1'b1;
      rd_addr = 19'h00077;
      tick();
      rd_req = 1'b0;
      tick(12);
      check("t6_overrun", 32'(rd_overrun), 1);
      check("t6_rd_outstanding", rd_q.size(), 0);

      // Reset in the middle of the WE pulse; that write is abandoned
      wr_req  = 1'b1;
      wr_addr = 19'h00040;
      wr_data = 8'h99;
      tick();
      wr_req = 1'b0;
      tick(2);
      check("t7_we_in_pulse", 32'(mem_we), 0);
      rst_n = 1'b0;
      #1;
      check("t7_we_async", 32'(mem_we), 1);
      check("t7_wr_ready", 32'(wr_ready), 1);
      check("t7_overrun_clr", 32'(rd_overrun), 0);
      check("t7_oe", 32'(mem_oe), 1);
      tick(2);
      rst_n = 1'b1;
      tick(8);
      check("t7_we_idle", 32'(mem_we), 1);

      check("end_rd_outstanding", rd_q.size(), 0);
      check("end_wr_outstanding", wr_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
